gate2_resp_checker: RTL and testbench

Synthesizable self-checking response checker for two-input gate primitives such as AND2 and OR2. On `start` it walks the four input vectors and holds each for a programmable number of cycles. It samples the gate output at the end of each hold, compares the sample against an expected truth table and accumulates mismatch results. It sits next to a gate instance in bring-up and regression harnesses, so gates can be checked on silicon or in emulation as well as in simulation.

---
 rtl/gate2_chk_pkg.sv | 26 ++
 rtl/gate2_chk_hold_ctr.sv | 43 ++++
 rtl/gate2_resp_checker.sv | 159 +++++++++++++++
 tb/tb_gate2_resp_checker.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gate2_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gate2_chk_pkg
//  Brief    : Shared types and constants for the two-input gate response checker.
//  Revision : 1.0 - initial release
// ============================================================================
package gate2_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0]  TRUTH_AND2 = 4'b1000;
    localparam logic [3:0]  TRUTH_OR2  = 4'b1110;
    localparam int unsigned NUM_VEC    = 4;

    function automatic logic is_last_vec(input logic [1:0] idx);
        return idx == 2'(NUM_VEC - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gate2_chk_hold_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : gate2_chk_hold_ctr
//  Brief    : Hold counter; tc is high on the last of HOLD enabled cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module gate2_chk_hold_ctr #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(HOLD) + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = (cnt_q == CW'(HOLD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gate2_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : gate2_resp_checker
//  Brief    : Walks the four input vectors of a 2-input gate, samples its output
//             and scores it against TRUTH. Optional macro GATE2_CHK_LOOP_EN makes
//             the checker rerun continuously, accumulating results.
//  Revision : 1.0 - initial release
// ============================================================================
module gate2_resp_checker
    import gate2_chk_pkg::*;
#(
    parameter logic [3:0] TRUTH = 4'b1000,
    parameter int         HOLD  = 4,
    parameter int         ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_o,
    output logic             dut_i1,
    output logic             dut_i2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       fail_vec
);

    generate
        if (HOLD < 1) begin : g_hold_check
            $error("gate2_resp_checker: HOLD must be at least 1");
        end
    endgenerate

`ifdef GATE2_CHK_LOOP_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       vec_q, vec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;

    logic             hold_tc;
    logic             launch;
    logic             mismatch;
    logic [ERR_W-1:0] err_inc;

    gate2_chk_hold_ctr #(
        .HOLD (HOLD)
    ) u_hold_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_q != ST_DRIVE),
        .en    (state_q == ST_DRIVE),
        .tc    (hold_tc)
    );

    // start is only honoured between runs; mid-run pulses are dropped.
    assign launch   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign mismatch = (dut_o != TRUTH[idx_q]);
    assign err_inc  = (err_q == '1) ? err_q : err_q + ERR_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        unique case (state_q)
            ST_IDLE: begin
                vec_d = 2'd0;
            end
            ST_DRIVE: begin
                if (hold_tc) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d         = err_inc;
                    fail_d[idx_q] = 1'b1;
                end
                if (!is_last_vec(idx_q)) begin
                    idx_d   = idx_q + 2'd1;
                    vec_d   = idx_q + 2'd1;
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    vec_d   = 2'd0;
                    busy_d  = LOOP;
                end
            end
            ST_DONE: begin
                idx_d = 2'd0;
                vec_d = 2'd0;
                state_d = LOOP ? ST_DRIVE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch) begin
            state_d = ST_DRIVE;
            idx_d   = 2'd0;
            vec_d   = 2'd0;
            busy_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = '0;
            fail_d  = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            vec_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign dut_i1   = vec_q[1];
    assign dut_i2   = vec_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_gate2_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate2_resp_checker
//  Brief    : Directed bench for gate2_resp_checker (AND2/OR2/stuck-at-0 DUTs).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate2_resp_checker;
    import gate2_chk_pkg::*;

`ifdef GATE2_CHK_LOOP_EN
    localparam int TB_ERR_W = 2;
`else
    localparam int TB_ERR_W = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sel = 1'b0;       // 0: checker A (AND2 truth), 1: checker B (OR2 truth)
    logic gate_or = 1'b0;   // gate model for checker A: 0 = AND2, 1 = OR2

    logic                i1_a, i2_a, busy_a, done_a, pass_a, dut_o_a;
    logic                i1_b, i2_b, busy_b, done_b, pass_b;
    logic [TB_ERR_W-1:0] err_a, err_b;
    logic [3:0]          fail_a, fail_b;

    logic                o_i1, o_i2, o_busy, o_done, o_pass;
    logic [TB_ERR_W-1:0] o_err;
    logic [3:0]          o_fail;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign dut_o_a = gate_or ? (i1_a | i2_a) : (i1_a & i2_a);

    gate2_resp_checker #(.TRUTH(TRUTH_AND2), .HOLD(4), .ERR_W(TB_ERR_W)) u_chk_a (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .dut_o(dut_o_a),
        .dut_i1(i1_a), .dut_i2(i2_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_cnt(err_a), .fail_vec(fail_a)
    );

    gate2_resp_checker #(.TRUTH(TRUTH_OR2), .HOLD(4), .ERR_W(TB_ERR_W)) u_chk_b (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .dut_o(1'b0),
        .dut_i1(i1_b), .dut_i2(i2_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_cnt(err_b), .fail_vec(fail_b)
    );

    always_comb begin
        o_i1 = sel ? i1_b : i1_a;
        o_i2 = sel ? i2_b : i2_a;
        o_busy = sel ? busy_b : busy_a;
        o_done = sel ? done_b : done_a;
        o_pass = sel ? pass_b : pass_a;
        o_err = sel ? err_b : err_a;
        o_fail = sel ? fail_b : fail_a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full run; vectors observed each cycle, done expected in cycle 21.
    task automatic run_check(input logic [3:0] exp_fail, input int exp_err,
                             input logic exp_pass, input int restart_at);
        int cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!o_done && cyc < 60) begin
            chk("busy_run", 32'(o_busy), 32'd1);
            chk("vec_run", 32'({o_i1, o_i2}), 32'((cyc - 1) / 5));
            start = (cyc == restart_at);
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("done_cycle", 32'(cyc), 32'd21);
        chk("busy_at_done", 32'(o_busy), 32'd0);
        chk("pass", 32'(o_pass), 32'(exp_pass));
        chk("err_cnt", 32'(o_err), 32'(exp_err));
        chk("fail_vec", 32'(o_fail), 32'(exp_fail));
        tick();
        chk("done_pulse", 32'(o_done), 32'd0);
        chk("idle_inputs", 32'({o_i1, o_i2}), 32'd0);
        chk("pass_hold", 32'(o_pass), 32'(exp_pass));
        chk("err_hold", 32'(o_err), 32'(exp_err));
    endtask

    initial begin
        int n_done;
        #12;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_pass", 32'(o_pass), 32'd0);
        chk("rst_inputs", 32'({o_i1, o_i2}), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_fail", 32'(o_fail), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

`ifdef GATE2_CHK_LOOP_EN
        sel = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int cyc = 1; cyc <= 43 && n_done < 2; cyc++) begin
            chk("loop_busy", 32'(o_busy), 32'd1);
            if (o_done) begin
                n_done++;
                chk("loop_done_cycle", 32'(cyc), 32'(21 * n_done));
                chk("loop_err_sat", 32'(o_err), 32'd3);
                chk("loop_fail_vec", 32'(o_fail), 32'b1110);
                chk("loop_pass", 32'(o_pass), 32'd0);
            end
            tick();
        end
        chk("loop_done_count", 32'(n_done), 32'd2);
`else
        // AND2 gate against AND2 truth
        sel = 1'b0; gate_or = 1'b0;
        run_check(4'b0000, 0, 1'b1, 0);

        // OR2 gate against AND2 truth
        gate_or = 1'b1;
        run_check(4'b0110, 2, 1'b0, 0);

        // Stuck-at-0 against OR2 truth
        sel = 1'b1;
        run_check(4'b1110, 3, 1'b0, 0);

        // start re-pulsed mid-run is ignored; also clears previous results
        sel = 1'b0; gate_or = 1'b0;
        run_check(4'b0000, 0, 1'b1, 8);

        // Reset during vector 2 aborts the run
        gate_or = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        chk("abort_pre_vec", 32'({o_i1, o_i2}), 32'd2);
        chk("abort_pre_err", 32'(o_err), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_inputs", 32'({o_i1, o_i2}), 32'd0);
        chk("abort_err", 32'(o_err), 32'd0);
        chk("abort_fail", 32'(o_fail), 32'd0);
        chk("abort_pass", 32'(o_pass), 32'd0);
        n_done = 0;
        repeat (12) begin
            tick();
            if (o_done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            tick();
            if (o_done || o_busy) n_done++;
        end
        chk("abort_stays_idle", 32'(n_done), 32'd0);
        gate_or = 1'b0;
        run_check(4'b0000, 0, 1'b1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
